ws2812_rx: RTL and testbench

- Receiver and decoder for the single-wire WS2812 NRZ pulse stream that the strip driver emits.
- Samples the line, classifies each high pulse as a 0 or 1 bit, and assembles bytes LSB-first (matching the driver's bit order).
- Writes each byte to a BRAM port at an incrementing address, and marks frame boundaries on the reset (long-low) gap.
- Used for loopback self-test of the strip driver and for receiving pixel data from an upstream controller.

---
 rtl/ws2812_rx_pkg.sv | 26 ++
 rtl/ws2812_rx_if.sv | 18 +
 rtl/ws2812_rx_sync_edge_detect.sv | 40 ++++
 rtl/ws2812_rx.sv | 196 +++++++++++++++++++
 tb/tb_ws2812_rx.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_rx_pkg.sv
// ----------------------------------------------------------------------------
// ws2812_rx_pkg
//   Timing constants shared by the WS2812 strip driver and receiver, plus the
//   receiver state encoding. All times are in clk cycles unless noted.
// ----------------------------------------------------------------------------
package ws2812_rx_pkg;

   // Driver-side pulse shapes.
   localparam int ZERO_PULSE_TIME  = 20;
   localparam int ONE_PULSE_TIME   = 50;
   localparam int TOTAL_PULSE_TIME = 70;
   localparam int RESET_PULSE_TIME = 50000;

   // Receiver-side decision points.
   // BIT_THRESHOLD sits between ZERO_PULSE_TIME and ONE_PULSE_TIME.
   localparam int BIT_THRESHOLD   = 35;
   // Low time that ends a frame: 50 us at 50 MHz.
   localparam int RESET_THRESHOLD = 2500;

   typedef enum logic [1:0] {
      SYNC = 2'd0,  // waiting for a full reset gap before decoding
      IDLE = 2'd1,  // line low, between bits or frames
      HIGH = 2'd2   // measuring a high pulse
   } rx_state_e;

endpackage

// File: rtl/ws2812_rx_if.sv
// ----------------------------------------------------------------------------
// ws2812_rx_if
//   Byte write port from the WS2812 receiver into a BRAM.
//   mem_we   : one-cycle write strobe
//   mem_addr : byte address within the frame
//   mem_din  : decoded byte
//   master = receiver (drives the port), slave = memory.
// ----------------------------------------------------------------------------
interface ws2812_rx_if #(
   parameter int ADDRESS_WIDTH = 13
);
   logic                     mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [7:0]               mem_din;

   modport master (output mem_we, output mem_addr, output mem_din);
   modport slave  (input  mem_we, input  mem_addr, input  mem_din);
endinterface

// File: rtl/ws2812_rx_sync_edge_detect.sv
// ----------------------------------------------------------------------------
// sync_edge_detect
//   Two-flop synchronizer for an asynchronous input, plus a third delayed
//   flop for edge detection. rise/fall are single-cycle pulses derived from
//   the synchronized level.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous input
//   level      : synchronized din
//   rise, fall : one-cycle edge pulses of level
// ----------------------------------------------------------------------------
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic meta_q;
   logic sync_q;
   logic dly_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign level = sync_q;
   assign rise  =  sync_q & ~dly_q;
   assign fall  = ~sync_q &  dly_q;
endmodule

// File: rtl/ws2812_rx.sv
// ----------------------------------------------------------------------------
// ws2812_rx
//   Receives a WS2812 NRZ stream, classifies each high pulse as a 0 or 1 by
//   its length, assembles bytes LSB-first and writes them to a BRAM at an
//   incrementing address. A long low gap ends the frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous WS2812 data line
//   mem        : BRAM write port (mem_we / mem_addr / mem_din)
//   frame_done : one-cycle pulse at the end of a non-empty frame
//   byte_count : bytes stored in the last frame, held until the next one
//   err        : sticky pulse-timing / framing error
//   overflow   : sticky, a byte arrived after MAX_BYTES were stored
// ----------------------------------------------------------------------------
module ws2812_rx #(
   parameter int ADDRESS_WIDTH   = 13,
   parameter int MAX_BYTES       = 480,
   parameter int BIT_THRESHOLD   = ws2812_rx_pkg::BIT_THRESHOLD,
   parameter int MIN_HIGH        = 5,
   parameter int MAX_HIGH        = 100,
   parameter int RESET_THRESHOLD = ws2812_rx_pkg::RESET_THRESHOLD
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     din,
   ws2812_rx_if.master              mem,
   output logic                     frame_done,
   output logic [ADDRESS_WIDTH-1:0] byte_count,
   output logic                     err,
   output logic                     overflow
);
   import ws2812_rx_pkg::*;

   localparam int HIGH_W = $clog2(MAX_HIGH + 1);
   localparam int LOW_W  = $clog2(RESET_THRESHOLD + 1);

   logic line, rise, fall;

   sync_edge_detect u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din),
      .level (line),
      .rise  (rise),
      .fall  (fall)
   );

   rx_state_e                state_q, state_d;
   logic [HIGH_W-1:0]        high_cnt_q, high_cnt_d;
   logic [LOW_W-1:0]         low_cnt_q, low_cnt_d;
   logic [7:0]               shift_q, shift_d;
   logic [2:0]               bit_idx_q, bit_idx_d;
   logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic                     mem_we_q, mem_we_d;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]               mem_din_q, mem_din_d;
   logic                     frame_done_q, frame_done_d;
   logic [ADDRESS_WIDTH-1:0] byte_count_q, byte_count_d;
   logic                     err_q, err_d;
   logic                     overflow_q, overflow_d;

   logic [HIGH_W-1:0] high_inc;
   logic [LOW_W-1:0]  low_inc;

   // Saturating increments: the counters park at all-ones, never wrap.
   assign high_inc = (high_cnt_q == '1) ? high_cnt_q : high_cnt_q + HIGH_W'(1);
   assign low_inc  = (low_cnt_q  == '1) ? low_cnt_q  : low_cnt_q  + LOW_W'(1);

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d      = state_q;
      high_cnt_d   = high_cnt_q;
      low_cnt_d    = low_cnt_q;
      shift_d      = shift_q;
      bit_idx_d    = bit_idx_q;
      wr_addr_d    = wr_addr_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_din_d    = mem_din_q;
      frame_done_d = 1'b0;
      byte_count_d = byte_count_q;
      err_d        = err_q;
      overflow_d   = overflow_q;

      unique case (state_q)
         SYNC: begin
            if (line) begin
               low_cnt_d = '0;
            end else begin
               low_cnt_d = low_inc;
               // Silent entry into decoding: any bytes seen before the first
               // complete gap belong to a frame we joined mid-way.
               if (low_inc == LOW_W'(RESET_THRESHOLD)) begin
                  state_d   = IDLE;
                  wr_addr_d = '0;
                  bit_idx_d = '0;
               end
            end
         end

         IDLE: begin
            if (rise) begin
               high_cnt_d = '0;
               state_d    = HIGH;
            end else if (!line) begin
               low_cnt_d = low_inc;
               // Fires only on the step onto the threshold, so once per gap;
               // the count keeps climbing past it afterwards.
               if (low_cnt_q == LOW_W'(RESET_THRESHOLD - 1)) begin
                  if (bit_idx_q != 3'd0) err_d = 1'b1;
                  if (wr_addr_q != '0) begin
                     frame_done_d = 1'b1;
                     byte_count_d = wr_addr_q;
                  end
                  wr_addr_d = '0;
                  bit_idx_d = '0;
               end
            end
         end

         HIGH: begin
            if (fall) begin
               state_d   = IDLE;
               low_cnt_d = '0;
               if (high_cnt_q < HIGH_W'(MIN_HIGH)) begin
                  err_d = 1'b1;  // glitch: bit dropped
               end else begin
                  shift_d[bit_idx_q] = (high_cnt_q >= HIGH_W'(BIT_THRESHOLD));
                  if (bit_idx_q == 3'd7) begin
                     bit_idx_d = '0;
                     if (wr_addr_q == ADDRESS_WIDTH'(MAX_BYTES)) begin
                        overflow_d = 1'b1;
                     end else begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = wr_addr_q;
                        mem_din_d  = shift_d;
                        wr_addr_d  = wr_addr_q + ADDRESS_WIDTH'(1);
                     end
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end
            end else begin
               high_cnt_d = high_inc;
               if (high_inc == HIGH_W'(MAX_HIGH)) begin
                  err_d     = 1'b1;
                  bit_idx_d = '0;
                  low_cnt_d = '0;
                  state_d   = SYNC;
               end
            end
         end

         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= SYNC;
         high_cnt_q   <= '0;
         low_cnt_q    <= '0;
         shift_q      <= '0;
         bit_idx_q    <= '0;
         wr_addr_q    <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         frame_done_q <= 1'b0;
         byte_count_q <= '0;
         err_q        <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         high_cnt_q   <= high_cnt_d;
         low_cnt_q    <= low_cnt_d;
         shift_q      <= shift_d;
         bit_idx_q    <= bit_idx_d;
         wr_addr_q    <= wr_addr_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         frame_done_q <= frame_done_d;
         byte_count_q <= byte_count_d;
         err_q        <= err_d;
         overflow_q   <= overflow_d;
      end
   end

   assign mem.mem_we   = mem_we_q;
   assign mem.mem_addr = mem_addr_q;
   assign mem.mem_din  = mem_din_q;
   assign frame_done   = frame_done_q;
   assign byte_count   = byte_count_q;
   assign err          = err_q;
   assign overflow     = overflow_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// ----------------------------------------------------------------------------
// tb_ws2812_rx
//   Directed bench for ws2812_rx. din is driven on the falling clock edge and
//   outputs are sampled on the falling edge. MAX_BYTES is reduced to 3 so the
//   overflow path is reachable in a short run; all timing thresholds keep
//   their default values.
// ----------------------------------------------------------------------------
module tb_ws2812_rx;
   import ws2812_rx_pkg::*;

   localparam int AW = 13;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          din = 1'b0;
   logic          frame_done;
   logic [AW-1:0] byte_count;
   logic          err;
   logic          overflow;

   int total = 0;
   int bad   = 0;

   ws2812_rx_if #(.ADDRESS_WIDTH(AW)) mem_bus ();

   ws2812_rx #(
      .ADDRESS_WIDTH (AW),
      .MAX_BYTES     (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .mem        (mem_bus.master),
      .frame_done (frame_done),
      .byte_count (byte_count),
      .err        (err),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Write / frame-end recorder.
   logic [AW-1:0] wr_addr_log [$];
   logic [7:0]    wr_din_log  [$];
   int            fd_n = 0;

   always @(negedge clk) begin
      if (mem_bus.mem_we) begin
         wr_addr_log.push_back(mem_bus.mem_addr);
         wr_din_log.push_back(mem_bus.mem_din);
      end
      if (frame_done) fd_n++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_low(input int n);
      din = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      din = 1'b1;
      repeat (b ? ONE_PULSE_TIME : ZERO_PULSE_TIME) @(negedge clk);
      din = 1'b0;
      repeat (b ? (TOTAL_PULSE_TIME - ONE_PULSE_TIME) : (TOTAL_PULSE_TIME - ZERO_PULSE_TIME)) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   int w0, f0;
   logic [7:0] ovf_bytes [3];
   logic [7:0] byte_a5;

   initial begin
      ovf_bytes[0] = 8'h11;
      ovf_bytes[1] = 8'h22;
      ovf_bytes[2] = 8'h33;
      byte_a5      = 8'hA5;

      // ---- reset state ----
      din = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mem_we",     32'(mem_bus.mem_we),   32'd0);
      check("rst_mem_addr",   32'(mem_bus.mem_addr), 32'd0);
      check("rst_mem_din",    32'(mem_bus.mem_din),  32'd0);
      check("rst_frame_done", 32'(frame_done),       32'd0);
      check("rst_byte_count", 32'(byte_count),       32'd0);
      check("rst_err",        32'(err),              32'd0);
      check("rst_overflow",   32'(overflow),         32'd0);
      rst_n = 1'b1;

      // ---- T1: high 1000, gap 2500, byte A5 with latency probe, gap ----
      repeat (1000) @(negedge clk);
      check("t1_state_sync", 32'(dut.state_q), 32'(SYNC));
      idle_low(RESET_THRESHOLD);
      for (int i = 0; i < 7; i++) send_bit(byte_a5[i]);
      din = 1'b1;
      repeat (ONE_PULSE_TIME) @(negedge clk);
      din = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t1_we_early",  32'(mem_bus.mem_we),   32'd0);
      @(negedge clk);
      check("t1_we_lat3",   32'(mem_bus.mem_we),   32'd1);
      check("t1_addr",      32'(mem_bus.mem_addr), 32'd0);
      check("t1_din",       32'(mem_bus.mem_din),  32'hA5);
      @(negedge clk);
      check("t1_we_1cyc",   32'(mem_bus.mem_we),   32'd0);
      idle_low(3000);
      check("t1_state_idle", 32'(dut.state_q),     32'(IDLE));
      check("t1_writes",     32'(wr_din_log.size()), 32'd1);
      check("t1_frames",     32'(fd_n),            32'd1);
      check("t1_byte_count", 32'(byte_count),      32'd1);
      check("t1_err",        32'(err),             32'd0);

      // ---- T2: 4 bytes with MAX_BYTES=3 -> overflow ----
      w0 = wr_din_log.size();
      f0 = fd_n;
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      check("t2_no_ovf_yet", 32'(overflow), 32'd0);
      send_byte(8'h44);
      idle_low(3000);
      check("t2_writes", 32'(wr_din_log.size() - w0), 32'd3);
      for (int k = 0; k < 3; k++) begin
         if (w0 + k < wr_din_log.size()) begin
            check($sformatf("t2_addr%0d", k), 32'(wr_addr_log[w0 + k]), 32'(k));
            check($sformatf("t2_din%0d", k),  32'(wr_din_log[w0 + k]),  32'(ovf_bytes[k]));
         end
      end
      check("t2_overflow",   32'(overflow),     32'd1);
      check("t2_frames",     32'(fd_n - f0),    32'd1);
      check("t2_byte_count", 32'(byte_count),   32'd3);
      check("t2_err",        32'(err),          32'd0);

      // ---- T3: 12 bits then gap -> err, one byte; next frame from addr 0 ----
      w0 = wr_din_log.size();
      f0 = fd_n;
      send_byte(8'h5A);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      check("t3_err_before_gap", 32'(err), 32'd0);
      idle_low(3000);
      check("t3_writes",     32'(wr_din_log.size() - w0), 32'd1);
      check("t3_addr",       32'(mem_bus.mem_addr), 32'd0);
      check("t3_din",        32'(mem_bus.mem_din),  32'h5A);
      check("t3_err",        32'(err),              32'd1);
      check("t3_frames",     32'(fd_n - f0),        32'd1);
      check("t3_byte_count", 32'(byte_count),       32'd1);
      send_byte(8'hC3);
      idle_low(3000);
      check("t3b_writes",     32'(wr_din_log.size() - w0), 32'd2);
      check("t3b_addr",       32'(mem_bus.mem_addr), 32'd0);
      check("t3b_din",        32'(mem_bus.mem_din),  32'hC3);
      check("t3b_frames",     32'(fd_n - f0),        32'd2);
      check("t3b_byte_count", 32'(byte_count),       32'd1);

      // ---- T4: 3-cycle glitch mid-byte -> err, bit dropped ----
      do_reset();
      check("t4_rst_err",      32'(err),        32'd0);
      check("t4_rst_overflow", 32'(overflow),   32'd0);
      check("t4_rst_count",    32'(byte_count), 32'd0);
      idle_low(2600);
      w0 = wr_din_log.size();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      din = 1'b1;
      repeat (3) @(negedge clk);
      idle_low(50);
      check("t4_err", 32'(err), 32'd1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      idle_low(3000);
      check("t4_writes",     32'(wr_din_log.size() - w0), 32'd1);
      check("t4_din",        32'(mem_bus.mem_din), 32'hA5);
      check("t4_byte_count", 32'(byte_count),      32'd1);

      // ---- T5: high held 150 cycles -> err, SYNC, no write until a gap ----
      do_reset();
      idle_low(2600);
      w0 = wr_din_log.size();
      f0 = fd_n;
      send_bit(1'b1);
      send_bit(1'b1);
      din = 1'b1;
      repeat (150) @(negedge clk);
      check("t5_err",        32'(err),           32'd1);
      check("t5_state_sync", 32'(dut.state_q),   32'(SYNC));
      din = 1'b0;
      send_byte(8'hFF);
      idle_low(100);
      check("t5_no_write",   32'(wr_din_log.size() - w0), 32'd0);
      check("t5_still_sync", 32'(dut.state_q),   32'(SYNC));
      idle_low(2600);
      check("t5_state_idle", 32'(dut.state_q),   32'(IDLE));
      check("t5_no_frame",   32'(fd_n - f0),     32'd0);
      send_byte(8'h3C);
      idle_low(3000);
      check("t5_writes",     32'(wr_din_log.size() - w0), 32'd1);
      check("t5_addr",       32'(mem_bus.mem_addr), 32'd0);
      check("t5_din",        32'(mem_bus.mem_din),  32'h3C);
      check("t5_frames",     32'(fd_n - f0),        32'd1);
      check("t5_byte_count", 32'(byte_count),       32'd1);

      // ---- T6: reset mid-byte (bit_idx=4) -> immediate clear, then SYNC ----
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      din = 1'b1;
      repeat (10) @(negedge clk);
      check("t6_bit_idx", 32'(dut.bit_idx_q), 32'd4);
      rst_n = 1'b0;
      #1;
      check("t6_async_din",   32'(mem_bus.mem_din),  32'd0);
      check("t6_async_count", 32'(byte_count),       32'd0);
      check("t6_async_err",   32'(err),              32'd0);
      check("t6_async_state", 32'(dut.state_q),      32'(SYNC));
      din = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      w0 = wr_din_log.size();
      f0 = fd_n;
      send_byte(8'h96);
      idle_low(100);
      check("t6_no_write", 32'(wr_din_log.size() - w0), 32'd0);
      idle_low(2600);
      send_byte(8'h69);
      idle_low(3000);
      check("t6_writes",     32'(wr_din_log.size() - w0), 32'd1);
      check("t6_addr",       32'(mem_bus.mem_addr), 32'd0);
      check("t6_din",        32'(mem_bus.mem_din),  32'h69);
      check("t6_frames",     32'(fd_n - f0),        32'd1);
      check("t6_byte_count", 32'(byte_count),       32'd1);
      check("t6_err",        32'(err),              32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
